// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode map and FSM state encoding shared by the sequential ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOTA = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_NOTB = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIV  = 4'hD;
    localparam logic [3:0] OP_EQ   = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_div_iter.sv
// ============================================================================
// Module : alu_div_iter
// Brief  : Iterative unsigned restoring divider, one quotient bit per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_div_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_d, quo_d;

    // quo_q doubles as the dividend shift register; its MSB feeds the trial.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        fits  = ~diff[WIDTH];
        rem_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Outputs present the final step's value so the consumer loads on the same edge.
    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

endmodule

`default_nettype wire

// File: rtl/alu_seq_handshake.sv
// ============================================================================
// Module : alu_seq_handshake
// Brief  : Registered WIDTH-bit ALU with valid/ready handshakes and an
//          iterative divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_handshake
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIV_BYPASS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [3:0]         op_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               flag_z_o,
    output logic               flag_c_o,
    output logic               err_dz_o
);

    localparam int DW = 2 * WIDTH;

    function automatic logic [DW-1:0] zext(input logic [WIDTH-1:0] v);
        return {{WIDTH{1'b0}}, v};
    endfunction

    state_e            state_q, state_d;
    logic              vld_q, vld_d;
    logic [DW-1:0]     res_q, res_d;
    logic              z_q, z_d, c_q, c_d, dz_q, dz_d;

    logic              accept, div_start, div_busy, div_done;
    logic [WIDTH-1:0]  div_quo, div_rem;
    logic              b_zero, is_div, dz_w;
    logic [WIDTH:0]    sum_w, inc_w;
    logic [WIDTH-1:0]  sub_w, dec_w, nota_w, notb_w, shr_w, rol_w;
    logic [DW-1:0]     alu_res;
    logic              alu_c;

    assign b_zero = (b_i == '0);
    assign is_div = (op_i == OP_DIV);

    // Divide-by-zero completes in one cycle and reports err_dz in either mode.
    if (DIV_BYPASS != 0) begin : g_dz_bypass
        assign dz_w = is_div && b_zero;
    end else begin : g_dz_flag
        assign dz_w = is_div && b_zero;
    end

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign inc_w  = {1'b0, a_i} + (WIDTH+1)'(1);
    assign sub_w  = a_i - b_i;
    assign dec_w  = a_i - WIDTH'(1);
    assign nota_w = ~a_i;
    assign notb_w = ~b_i;
    assign shr_w  = a_i >> 1;
    assign rol_w  = {a_i[WIDTH-2:0], a_i[WIDTH-1]};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_i)
            OP_ADD:  begin alu_res = {{(WIDTH-1){1'b0}}, sum_w}; alu_c = sum_w[WIDTH]; end
            OP_SUB:  begin alu_res = zext(sub_w); alu_c = (a_i < b_i); end
            OP_AND:  alu_res = zext(a_i & b_i);
            OP_OR:   alu_res = zext(a_i | b_i);
            OP_XOR:  alu_res = zext(a_i ^ b_i);
            OP_NOTA: alu_res = zext(nota_w);
            OP_INC:  begin alu_res = {{(WIDTH-1){1'b0}}, inc_w}; alu_c = inc_w[WIDTH]; end
            OP_DEC:  begin alu_res = zext(dec_w); alu_c = (a_i == '0); end
            OP_SHL:  alu_res = {{(WIDTH-1){1'b0}}, a_i, 1'b0};
            OP_SHR:  alu_res = zext(shr_w);
            OP_ROL:  alu_res = zext(rol_w);
            OP_NOTB: alu_res = zext(notb_w);
            OP_MUL:  alu_res = zext(a_i) * zext(b_i);
            OP_EQ:   alu_res = {{(DW-1){1'b0}}, (a_i == b_i)};
            default: alu_res = '0;
        endcase
    end

    alu_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .dividend_i  (a_i),
        .divisor_i   (b_i),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign in_ready_o = (state_q == IDLE) && !div_busy && (!vld_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d   = state_q;
        vld_d     = vld_q && !out_ready_i;
        res_d     = res_q;
        z_d       = z_q;
        c_d       = c_q;
        dz_d      = dz_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_div && !b_zero) begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end else begin
                        vld_d = 1'b1;
                        res_d = alu_res;
                        z_d   = (alu_res == '0);
                        c_d   = alu_c;
                        dz_d  = dz_w;
                    end
                end
            end
            DIV: begin
                // The output register was drained on the accept edge, so load unconditionally.
                if (div_done) begin
                    vld_d   = 1'b1;
                    res_d   = {div_rem, div_quo};
                    z_d     = ({div_rem, div_quo} == '0);
                    c_d     = 1'b0;
                    dz_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
        end
    end

    assign out_valid_o = vld_q;
    assign result_o    = res_q;
    assign flag_z_o    = z_q;
    assign flag_c_o    = c_q;
    assign err_dz_o    = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_handshake.sv
// ============================================================================
// Module : tb_alu_seq_handshake
// Brief  : Scoreboard bench for alu_seq_handshake (WIDTH=8 and WIDTH=16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_handshake;
    import alu_pkg::*;

    logic clk;
    logic rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [3:0]  op;
    logic [15:0] result;
    logic        flag_z, flag_c, err_dz;

    logic        v16, rdy16, ov16, ordy16;
    logic [15:0] a16, b16;
    logic [3:0]  op16;
    logic [31:0] res16;
    logic        z16, c16, dz16;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    alu_seq_handshake #(.WIDTH(8), .DIV_BYPASS(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .op_i(op),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .flag_z_o(flag_z), .flag_c_o(flag_c), .err_dz_o(err_dz)
    );

    alu_seq_handshake #(.WIDTH(16), .DIV_BYPASS(1)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid_i(v16), .in_ready_o(rdy16),
        .a_i(a16), .b_i(b16), .op_i(op16),
        .out_valid_o(ov16), .out_ready_i(ordy16),
        .result_o(res16), .flag_z_o(z16), .flag_c_o(c16), .err_dz_o(dz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ia, ib, r;
        ia = int'(x);
        ib = int'(y);
        r  = 0;
        e.c  = 1'b0;
        e.dz = 1'b0;
        case (o)
            4'h0: begin r = ia + ib; e.c = (r > 255); end
            4'h1: begin r = (ia - ib + 256) % 256; e.c = (ia < ib); end
            4'h2: r = int'(x & y);
            4'h3: r = int'(x | y);
            4'h4: r = int'(x ^ y);
            4'h5: r = 255 - ia;
            4'h6: begin r = ia + 1; e.c = (r > 255); end
            4'h7: begin r = (ia + 255) % 256; e.c = (ia == 0); end
            4'h8: r = ia * 2;
            4'h9: r = ia / 2;
            4'hA: r = (ia * 2) % 256 + ia / 128;
            4'hB: r = 255 - ib;
            4'hC: r = ia * ib;
            4'hD: if (ib == 0) e.dz = 1'b1; else r = (ia % ib) * 256 + ia / ib;
            4'hE: r = (ia == ib) ? 1 : 0;
            default: r = 0;
        endcase
        e.res = 16'(r);
        e.z   = (r == 0);
        return e;
    endfunction

    // Transfers are judged at the negedge preceding the edge that completes them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_result", 32'(result), 32'(mon_e.res));
                check("sb_flag_z", 32'(flag_z), 32'(mon_e.z));
                check("sb_flag_c", 32'(flag_c), 32'(mon_e.c));
                check("sb_err_dz", 32'(err_dz), 32'(mon_e.dz));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input bit push, output int waited);
        op = o; a = x; b = y; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
        end
        if (!in_ready) check("issue_timeout", 32'd0, 32'd1);
        else if (push) sb.push_back(model(o, x, y));
        tick();
    endtask

    initial begin
        int w, lat, stale, n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        v16 = 1'b0; ordy16 = 1'b1; a16 = '0; b16 = '0; op16 = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_flags",     32'({flag_z, flag_c, err_dz}), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        issue(OP_ADD, 8'hFF, 8'h01, 1'b1, w);
        in_valid = 1'b0;
        check("add_latency", 32'(out_valid), 32'd1);
        check("add_result",  32'(result),    32'h0100);
        check("add_flag_c",  32'(flag_c),    32'd1);
        check("add_flag_z",  32'(flag_z),    32'd0);

        issue(OP_SUB, 8'd3, 8'd5, 1'b1, w);
        in_valid = 1'b0;
        check("sub_result", 32'(result), 32'h00FE);
        check("sub_flag_c", 32'(flag_c), 32'd1);
        tick();

        out_ready = 1'b0;
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b1, w);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result",    32'(result),    32'hFE01);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        issue(OP_DIV, 8'd200, 8'd7, 1'b1, w);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("div_in_ready_busy", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check("div_latency", 32'(lat),    32'd9);
        check("div_result",  32'(result), 32'h041C);

        issue(OP_DIV, 8'd50, 8'd0, 1'b1, w);
        in_valid = 1'b0;
        check("dz_latency", 32'(out_valid), 32'd1);
        check("dz_result",  32'(result),    32'd0);
        check("dz_err",     32'(err_dz),    32'd1);
        check("dz_flag_z",  32'(flag_z),    32'd1);

        issue(OP_ADD, 8'h12, 8'h34, 1'b1, w);
        check("stream_add_wait", 32'(w), 32'd0);
        check("stream_add", 32'({out_valid, result}), 32'h1_0046);
        issue(OP_EQ, 8'd9, 8'd9, 1'b1, w);
        check("stream_eq_wait", 32'(w), 32'd0);
        check("stream_eq", 32'({out_valid, result}), 32'h1_0001);
        issue(OP_NOP, 8'h55, 8'hAA, 1'b1, w);
        check("stream_nop_wait", 32'(w), 32'd0);
        check("stream_nop", 32'({out_valid, result}), 32'h1_0000);
        issue(OP_ROL, 8'h81, 8'h00, 1'b1, w);
        check("stream_rol_wait", 32'(w), 32'd0);
        check("stream_rol", 32'({out_valid, result}), 32'h1_0003);
        in_valid = 1'b0;
        tick();

        issue(OP_DIV, 8'd200, 8'd7, 1'b0, w);
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_div_out_valid", 32'(out_valid), 32'd0);
        check("rst_div_result",    32'(result),    32'd0);
        check("rst_div_in_ready",  32'(in_ready),  32'd1);
        stale = 0;
        repeat (12) begin
            if (out_valid) stale++;
            tick();
        end
        check("rst_div_stale", 32'(stale), 32'd0);

        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            issue(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 255)), 1'b1, w);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        repeat (20) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        a16 = 16'hFFFF; b16 = 16'h0002; op16 = OP_MUL; v16 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy16 && n < 20) begin
            n++;
            @(negedge clk);
        end
        tick();
        v16 = 1'b0;
        check("w16_ready",     32'(n),     32'd0);
        check("w16_out_valid", 32'(ov16),  32'd1);
        check("w16_mul",       res16,      32'h0001FFFE);
        check("w16_flags",     32'({z16, c16, dz16}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
